// File: rtl/pipe_ctl_chain_if.sv
// Bundle of ID-stage controls in and EX/MEM/WB controls out for the
// pipeline control chain. The master drives ID controls, the chain is the slave.
interface pipe_ctl_chain_if #(
    parameter int CNT_W = 32
);
    logic             wpcir;
    logic             d_valid;
    logic             d_wreg;
    logic             d_m2reg;
    logic             d_wmem;
    logic             d_jal;
    logic [3:0]       d_aluc;
    logic             d_aluimm;
    logic             d_shift;
    logic             d_regrt;
    logic [4:0]       d_rd;
    logic [4:0]       d_rt;
    logic             cnt_clr;

    logic             ewreg;
    logic             em2reg;
    logic             ewmem;
    logic             ejal;
    logic             ealuimm;
    logic             eshift;
    logic [3:0]       ealuc;
    logic [4:0]       ern;
    logic             mwreg;
    logic             mm2reg;
    logic             mwmem;
    logic [4:0]       mrn;
    logic             wwreg;
    logic             wm2reg;
    logic [4:0]       wrn;
    logic [CNT_W-1:0] cnt_retire;
    logic [CNT_W-1:0] cnt_stall;

    modport master (
        output wpcir, d_valid, d_wreg, d_m2reg, d_wmem, d_jal, d_aluc,
               d_aluimm, d_shift, d_regrt, d_rd, d_rt, cnt_clr,
        input  ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern,
               mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn,
               cnt_retire, cnt_stall
    );

    modport slave (
        input  wpcir, d_valid, d_wreg, d_m2reg, d_wmem, d_jal, d_aluc,
               d_aluimm, d_shift, d_regrt, d_rd, d_rt, cnt_clr,
        output ewreg, em2reg, ewmem, ejal, ealuimm, eshift, ealuc, ern,
               mwreg, mm2reg, mwmem, mrn, wwreg, wm2reg, wrn,
               cnt_retire, cnt_stall
    );
endinterface

// File: rtl/pipe_ctl_chain.sv
// ID/EX, EX/MEM and MEM/WB control-plus-destination registers for the
// 5-stage CPU. Inserts a bubble into EX on load-use stall and keeps
// saturating retire/stall counters. Every output is a flop output.
module pipe_ctl_chain #(
    parameter int CNT_W = 32
) (
    input  logic             clock,
    input  logic             resetn,
    pipe_ctl_chain_if.slave  bus
);
    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic       jal;
        logic [3:0] aluc;
        logic       aluimm;
        logic       shift;
        logic [4:0] rn;
    } ex_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic       wmem;
        logic [4:0] rn;
    } mem_t;

    typedef struct packed {
        logic       valid;
        logic       wreg;
        logic       m2reg;
        logic [4:0] rn;
    } wb_t;

    ex_t              ex_nxt, ex_q;
    mem_t             mem_q;
    wb_t              wb_q;
    logic [4:0]       d_rn;
    logic [CNT_W-1:0] cnt_retire, cnt_stall;

    // Destination select and EX next value; a stall forces a full bubble
    // (rn=0, wreg=0) so it can never match a hazard/forwarding compare.
    always_comb begin
        d_rn   = bus.d_jal ? 5'd31 : (bus.d_regrt ? bus.d_rt : bus.d_rd);
        ex_nxt = '0;
        if (bus.wpcir) begin
            ex_nxt.valid  = bus.d_valid;
            ex_nxt.wreg   = bus.d_wreg;
            ex_nxt.m2reg  = bus.d_m2reg;
            ex_nxt.wmem   = bus.d_wmem;
            ex_nxt.jal    = bus.d_jal;
            ex_nxt.aluc   = bus.d_aluc;
            ex_nxt.aluimm = bus.d_aluimm;
            ex_nxt.shift  = bus.d_shift;
            ex_nxt.rn     = d_rn;
        end
    end

    // All stages advance together every edge; reset flushes in-flight work.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_nxt;
            mem_q <= '{valid: ex_q.valid, wreg: ex_q.wreg, m2reg: ex_q.m2reg,
                       wmem: ex_q.wmem, rn: ex_q.rn};
            wb_q  <= '{valid: mem_q.valid, wreg: mem_q.wreg,
                       m2reg: mem_q.m2reg, rn: mem_q.rn};
        end
    end

    // Saturating performance counters; clear beats increment, reset beats clear.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            cnt_retire <= '0;
            cnt_stall  <= '0;
        end else if (bus.cnt_clr) begin
            cnt_retire <= '0;
            cnt_stall  <= '0;
        end else begin
            if (wb_q.valid && (cnt_retire != '1))
                cnt_retire <= cnt_retire + 1'b1;
            if (!bus.wpcir && (cnt_stall != '1))
                cnt_stall <= cnt_stall + 1'b1;
        end
    end

    assign bus.ewreg      = ex_q.wreg;
    assign bus.em2reg     = ex_q.m2reg;
    assign bus.ewmem      = ex_q.wmem;
    assign bus.ejal       = ex_q.jal;
    assign bus.ealuimm    = ex_q.aluimm;
    assign bus.eshift     = ex_q.shift;
    assign bus.ealuc      = ex_q.aluc;
    assign bus.ern        = ex_q.rn;
    assign bus.mwreg      = mem_q.wreg;
    assign bus.mm2reg     = mem_q.m2reg;
    assign bus.mwmem      = mem_q.wmem;
    assign bus.mrn        = mem_q.rn;
    assign bus.wwreg      = wb_q.wreg;
    assign bus.wm2reg     = wb_q.m2reg;
    assign bus.wrn        = wb_q.rn;
    assign bus.cnt_retire = cnt_retire;
    assign bus.cnt_stall  = cnt_stall;
endmodule

// File: tb/tb_pipe_ctl_chain.sv
// Self-checking bench for pipe_ctl_chain: directed scenarios followed by
// random traffic, compared against a record-of-issued-instructions model.
// Counters are built 4 bits wide so saturation is reachable quickly.
module tb_pipe_ctl_chain;
    localparam int CNT_W = 4;
    localparam int unsigned CMAX = (1 << CNT_W) - 1;

    typedef struct {
        bit       valid, wreg, m2reg, wmem, jal;
        bit [3:0] aluc;
        bit       aluimm, shift;
        bit [4:0] rn;
    } ins_t;

    logic clock = 1'b0;
    logic resetn;
    pipe_ctl_chain_if #(.CNT_W(CNT_W)) bus ();

    pipe_ctl_chain #(.CNT_W(CNT_W)) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus.slave)
    );

    always #5 clock = ~clock;

    // q[0] = what EX holds, q[1] = MEM, q[2] = WB
    ins_t        q[3];
    int unsigned exp_ret, exp_stl;
    int          npass = 0, ntot = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        if (obs === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    // One clock edge: advance the model from the current inputs, then check.
    task automatic step();
        ins_t n;
        n = '{default: 0};
        if (bus.wpcir) begin
            n.valid  = bus.d_valid;
            n.wreg   = bus.d_wreg;
            n.m2reg  = bus.d_m2reg;
            n.wmem   = bus.d_wmem;
            n.jal    = bus.d_jal;
            n.aluc   = bus.d_aluc;
            n.aluimm = bus.d_aluimm;
            n.shift  = bus.d_shift;
            n.rn     = bus.d_jal ? 5'd31 : (bus.d_regrt ? bus.d_rt : bus.d_rd);
        end
        if (!resetn) begin
            for (int i = 0; i < 3; i++) q[i] = '{default: 0};
            exp_ret = 0;
            exp_stl = 0;
        end else begin
            if (bus.cnt_clr) begin
                exp_ret = 0;
                exp_stl = 0;
            end else begin
                if (q[2].valid && exp_ret < CMAX) exp_ret++;
                if (!bus.wpcir && exp_stl < CMAX) exp_stl++;
            end
            q[2] = q[1];
            q[1] = q[0];
            q[0] = n;
        end
        @(posedge clock);
        #1;
        chk("ex", {bus.ewreg, bus.em2reg, bus.ewmem, bus.ejal, bus.ealuc,
                   bus.ealuimm, bus.eshift, bus.ern},
                  {q[0].wreg, q[0].m2reg, q[0].wmem, q[0].jal, q[0].aluc,
                   q[0].aluimm, q[0].shift, q[0].rn});
        chk("mem", {bus.mwreg, bus.mm2reg, bus.mwmem, bus.mrn},
                   {q[1].wreg, q[1].m2reg, q[1].wmem, q[1].rn});
        chk("wb", {bus.wwreg, bus.wm2reg, bus.wrn},
                  {q[2].wreg, q[2].m2reg, q[2].rn});
        chk("cnt_retire", 32'(bus.cnt_retire), exp_ret);
        chk("cnt_stall", 32'(bus.cnt_stall), exp_stl);
    endtask

    // Present one ID instruction with no stall and no clear.
    task automatic id(input bit v, w, m2, wm, j, rsel, input bit [4:0] rd, rt);
        bus.wpcir    = 1'b1;
        bus.cnt_clr  = 1'b0;
        bus.d_valid  = v;
        bus.d_wreg   = w;
        bus.d_m2reg  = m2;
        bus.d_wmem   = wm;
        bus.d_jal    = j;
        bus.d_regrt  = rsel;
        bus.d_rd     = rd;
        bus.d_rt     = rt;
        bus.d_aluc   = 4'd0;
        bus.d_aluimm = 1'b0;
        bus.d_shift  = 1'b0;
    endtask

    task automatic idle();
        id(0, 0, 0, 0, 0, 0, 5'd0, 5'd0);
    endtask

    initial begin
        // reset with every input high
        resetn = 1'b0;
        bus.wpcir = 1'b1; bus.cnt_clr = 1'b1; bus.d_valid = 1'b1;
        bus.d_wreg = 1'b1; bus.d_m2reg = 1'b1; bus.d_wmem = 1'b1;
        bus.d_jal = 1'b1; bus.d_aluc = 4'hf; bus.d_aluimm = 1'b1;
        bus.d_shift = 1'b1; bus.d_regrt = 1'b1; bus.d_rd = 5'd7; bus.d_rt = 5'd7;
        #2;
        step();
        step();
        chk("rst_ern", 32'(bus.ern), 0);
        chk("rst_ewreg", 32'(bus.ewreg), 0);
        resetn = 1'b1;

        // add r3: EX, MEM, WB, then retire count
        id(1, 1, 0, 0, 0, 0, 5'd3, 5'd9);
        step();
        chk("add_ern", 32'(bus.ern), 3);
        chk("add_ewreg", 32'(bus.ewreg), 1);
        idle(); step();
        chk("add_mrn", 32'(bus.mrn), 3);
        step();
        chk("add_wrn", 32'({bus.wwreg, bus.wrn}), {27'd0, 1'b1, 5'd3});
        step();
        chk("add_retire", 32'(bus.cnt_retire), 1);

        // lw r5 followed by a load-use stall
        id(1, 1, 1, 0, 0, 1, 5'd0, 5'd5);
        step();
        chk("lw_ern", 32'({bus.em2reg, bus.ern}), {26'd0, 1'b1, 5'd5});
        id(1, 1, 0, 1, 0, 0, 5'd6, 5'd5);
        bus.wpcir = 1'b0;
        step();
        chk("bub_ex", 32'({bus.ewreg, bus.ewmem, bus.ern}), 0);
        chk("bub_mrn", 32'({bus.mm2reg, bus.mrn}), {26'd0, 1'b1, 5'd5});
        chk("stall_cnt", 32'(bus.cnt_stall), 1);

        // jal always targets r31
        id(1, 1, 0, 0, 1, 1, 5'd2, 5'd4);
        step();
        chk("jal_ern", 32'({bus.ejal, bus.ern}), {26'd0, 1'b1, 5'd31});
        idle(); step();
        chk("jal_mrn", 32'(bus.mrn), 31);

        // 20 back-to-back valid instructions saturate the retire counter
        for (int i = 0; i < 20; i++) begin
            id(1, 1, 0, 0, 0, 0, 5'(i + 1), 5'd0);
            step();
        end
        idle();
        for (int i = 0; i < 4; i++) step();
        chk("sat_retire", 32'(bus.cnt_retire), CMAX);

        // clear on the edge a valid instruction retires, with a stall
        id(1, 1, 0, 0, 0, 0, 5'd8, 5'd0);
        step();
        idle(); step(); step();
        bus.wpcir = 1'b0;
        bus.cnt_clr = 1'b1;
        step();
        chk("clr_retire", 32'(bus.cnt_retire), 0);
        chk("clr_stall", 32'(bus.cnt_stall), 0);

        // random traffic with occasional reset and clear
        for (int i = 0; i < 400; i++) begin
            resetn       = ($urandom_range(39) != 0);
            bus.wpcir    = ($urandom_range(3) != 0);
            bus.cnt_clr  = ($urandom_range(29) == 0);
            bus.d_valid  = 1'($urandom);
            bus.d_wreg   = 1'($urandom);
            bus.d_m2reg  = 1'($urandom);
            bus.d_wmem   = 1'($urandom);
            bus.d_jal    = ($urandom_range(7) == 0);
            bus.d_aluc   = 4'($urandom);
            bus.d_aluimm = 1'($urandom);
            bus.d_shift  = 1'($urandom);
            bus.d_regrt  = 1'($urandom);
            bus.d_rd     = 5'($urandom);
            bus.d_rt     = 5'($urandom);
            step();
        end

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule
